// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
// Fetch-side bus between the PC sequencer and the instruction-fetch consumer
// and redirect sources.
//
// Signals:
//   fetch_ready    consumer accepts the current PC offer
//   redirect_valid single-cycle branch/jump redirect request
//   redirect_pc    redirect target (low two bits dropped by the sequencer)
//   halt_req       level request to stop fetching
//   trap_valid     single-cycle trap request (only with PC_TRAP_EN defined)
//   pc_out         current fetch address (registered)
//   fetch_valid    pc_out is a valid fetch offer (registered)
//   misalign_err   one-cycle pulse: redirect target had nonzero bits [1:0]
//   halted         high while the sequencer is in HALT
//
// Modports: master = sequencer side, slave = consumer / redirect source side.
// Optional feature macro: PC_TRAP_EN.
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            fetch_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt_req;
`ifdef PC_TRAP_EN
    logic            trap_valid;
`endif
    logic [XLEN-1:0] pc_out;
    logic            fetch_valid;
    logic            misalign_err;
    logic            halted;

    modport master (
        input  fetch_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
`ifdef PC_TRAP_EN
        input  trap_valid,
`endif
        output pc_out,
        output fetch_valid,
        output misalign_err,
        output halted
    );

    modport slave (
        output fetch_ready,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
`ifdef PC_TRAP_EN
        output trap_valid,
`endif
        input  pc_out,
        input  fetch_valid,
        input  misalign_err,
        input  halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Generates the instruction fetch address stream. A three-state FSM
// (BOOT -> RUN <-> HALT) gates the fetch offer; the PC advances by INC on an
// accepted offer, jumps on redirect (word aligned) and, when enabled, on trap.
// Every output is a register or a decode of the state register, so each input
// acts on the outputs exactly one cycle after it is sampled.
//
// Ports:
//   i_clock  single clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      pc_sequencer_if.master (fetch handshake, redirect, halt, status)
//
// Optional feature macro: PC_TRAP_EN (adds trap_valid and the TRAP_VECTOR jump).
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int unsigned       INC          = 4,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    pc_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_misalign;
    logic            w_misalign_nxt;
    logic            w_fetch_valid;
    logic            w_halted;
    logic            w_trap;
    logic            w_accept;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

`ifdef PC_TRAP_EN
    assign w_trap = bus.trap_valid;
`else
    assign w_trap = 1'b0;
    logic w_unused_trap_vector;
    assign w_unused_trap_vector = ^TRAP_VECTOR;
`endif

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a trap pulls the FSM out of HALT (or BOOT) into RUN
    always_comb begin
        w_state_nxt = r_state;
        if (w_trap) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_BOOT:         w_state_nxt = S_RUN;
                S_RUN, S_HALT:  w_state_nxt = bus.halt_req ? S_HALT : S_RUN;
                default:        w_state_nxt = S_BOOT;
            endcase
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        w_fetch_valid = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            S_RUN:   w_fetch_valid = 1'b1;
            S_HALT:  w_halted      = 1'b1;
            default: ;
        endcase
    end

    // A halt request outranks acceptance, so the offered PC is not consumed
    // in the cycle the halt is sampled.
    assign w_accept = w_fetch_valid & bus.fetch_ready & ~bus.halt_req;

    always_comb begin
        w_pc_nxt       = r_pc;
        w_misalign_nxt = 1'b0;
        if (w_trap) begin
            w_pc_nxt = TRAP_VECTOR;
        end else if (bus.redirect_valid) begin
            w_pc_nxt       = align_pc(bus.redirect_pc);
            w_misalign_nxt = |bus.redirect_pc[1:0];
        end else if (w_accept) begin
            w_pc_nxt = r_pc + XLEN'(INC);
        end
    end

    // PC and misalignment flag registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign bus.pc_out       = r_pc;
    assign bus.fetch_valid  = w_fetch_valid;
    assign bus.misalign_err = r_misalign;
    assign bus.halted       = w_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int XLEN = 32;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        mis;
        logic        hlt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_sequencer #(.XLEN(XLEN)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    int          m_st;
    logic [31:0] m_pc;
    logic        m_mis;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the outputs after the next edge,
    // then compare the DUT against the popped prediction.
    task automatic drive(input string tag, input logic r, input logic rdy, input logic rv,
                         input logic [31:0] rpc, input logic hr, input logic tv);
        exp_t e;
        logic acc;
        logic tv_eff;
        rst                = r;
        bus.fetch_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt_req       = hr;
`ifdef PC_TRAP_EN
        bus.trap_valid     = tv;
        tv_eff             = tv;
`else
        tv_eff             = 1'b0;
`endif
        if (r) begin
            m_pc  = 32'h0;
            m_st  = M_BOOT;
            m_mis = 1'b0;
        end else if (tv_eff) begin
            m_pc  = 32'h0000_0100;
            m_st  = M_RUN;
            m_mis = 1'b0;
        end else begin
            acc   = (m_st == M_RUN) && rdy && !hr;
            m_mis = rv && (rpc[1:0] != 2'b00);
            if (rv)       m_pc = rpc & 32'hFFFF_FFFC;
            else if (acc) m_pc = m_pc + 32'd4;
            if (m_st == M_BOOT) m_st = M_RUN;
            else                m_st = hr ? M_HALT : M_RUN;
        end
        e.pc  = m_pc;
        e.vld = (m_st == M_RUN);
        e.hlt = (m_st == M_HALT);
        e.mis = m_mis;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_pc"},  64'(bus.pc_out),       64'(e.pc));
        chk({tag, "_vld"}, 64'(bus.fetch_valid),  64'(e.vld));
        chk({tag, "_mis"}, 64'(bus.misalign_err), 64'(e.mis));
        chk({tag, "_hlt"}, 64'(bus.halted),       64'(e.hlt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r, rdy, rv, hr, tv;
        logic [31:0] rpc;
        rst = 1'b1;
        bus.fetch_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt_req       = 1'b0;
`ifdef PC_TRAP_EN
        bus.trap_valid     = 1'b0;
`endif
        m_st = M_BOOT; m_pc = '0; m_mis = 1'b0;
        @(negedge clk);

        // Reset for three cycles; outputs sit at the BOOT values
        repeat (3) drive("rst", 1, 1, 0, 0, 0, 0);
        chk("boot_pc",  64'(bus.pc_out), 64'h0);
        chk("boot_vld", 64'(bus.fetch_valid), 64'h0);
        chk("boot_hlt", 64'(bus.halted), 64'h0);

        // Release: PC 0,4,8 offered with fetch_valid high
        drive("run0", 0, 1, 0, 0, 0, 0);
        chk("run0_dir", 64'({bus.fetch_valid, bus.pc_out}), 64'({1'b1, 32'h0}));
        drive("run4", 0, 1, 0, 0, 0, 0);
        chk("run4_dir", 64'(bus.pc_out), 64'h4);
        drive("run8", 0, 1, 0, 0, 0, 0);
        chk("run8_dir", 64'(bus.pc_out), 64'h8);

        // Stall at 8 for three cycles, then accept -> 12
        repeat (3) begin
            drive("stall", 0, 0, 0, 0, 0, 0);
            chk("stall_dir", 64'({bus.fetch_valid, bus.pc_out}), 64'({1'b1, 32'h8}));
        end
        drive("unstall", 0, 1, 0, 0, 0, 0);
        chk("unstall_dir", 64'(bus.pc_out), 64'hC);

        // Misaligned redirect during acceptance: aligned target, one-cycle flag
        drive("redir", 0, 1, 1, 32'h0000_1002, 0, 0);
        chk("redir_pc_dir",  64'(bus.pc_out), 64'h1000);
        chk("redir_mis_dir", 64'(bus.misalign_err), 64'h1);
        drive("redir_next", 0, 1, 0, 0, 0, 0);
        chk("redir_next_dir", 64'({bus.misalign_err, bus.pc_out}), 64'({1'b0, 32'h1004}));

        // Wrap from the top of the address space
        drive("to_top", 0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        chk("to_top_dir", 64'(bus.pc_out), 64'hFFFF_FFFC);
        drive("wrap", 0, 1, 0, 0, 0, 0);
        chk("wrap_dir", 64'({bus.misalign_err, bus.pc_out}), 64'({1'b0, 32'h0}));
        drive("post_wrap", 0, 1, 0, 0, 0, 0);

        // Halt and redirect together, then resume at the redirect target
        drive("halt_redir", 0, 1, 1, 32'h0000_0200, 1, 0);
        chk("halt_redir_dir", 64'({bus.halted, bus.fetch_valid, bus.pc_out}),
            64'({1'b1, 1'b0, 32'h200}));
        drive("halt_hold", 0, 1, 0, 0, 1, 0);
        chk("halt_hold_dir", 64'(bus.pc_out), 64'h200);
        drive("resume", 0, 1, 0, 0, 0, 0);
        chk("resume_dir", 64'({bus.halted, bus.fetch_valid, bus.pc_out}),
            64'({1'b0, 1'b1, 32'h200}));
        drive("resume_acc", 0, 1, 0, 0, 0, 0);
        chk("resume_acc_dir", 64'(bus.pc_out), 64'h204);

        // Redirect while halted: PC moves, stays halted
        drive("halt2", 0, 0, 0, 0, 1, 0);
        drive("halt2_redir", 0, 1, 1, 32'h0000_0301, 1, 0);
        chk("halt2_redir_dir", 64'({bus.halted, bus.fetch_valid, bus.misalign_err, bus.pc_out}),
            64'({1'b1, 1'b0, 1'b1, 32'h300}));
        drive("halt2_exit", 0, 1, 0, 0, 0, 0);
        drive("halt2_acc", 0, 1, 0, 0, 0, 0);
        chk("halt2_acc_dir", 64'(bus.pc_out), 64'h304);

        // Reset wins over a coincident redirect mid-stall
        drive("pre_rst_stall", 0, 0, 0, 0, 0, 0);
        drive("rst_redir", 1, 0, 1, 32'h0000_0503, 0, 1);
        chk("rst_redir_dir", 64'({bus.fetch_valid, bus.misalign_err, bus.pc_out}),
            64'({1'b0, 1'b0, 32'h0}));
        drive("rst_redir_rel", 0, 1, 0, 0, 0, 0);

        // Reset mid-halt
        drive("pre_rst_halt", 0, 0, 0, 0, 1, 0);
        drive("rst_halt", 1, 0, 0, 0, 1, 0);
        chk("rst_halt_dir", 64'(bus.halted), 64'h0);
        drive("rst_halt_rel", 0, 1, 0, 0, 0, 0);

`ifdef PC_TRAP_EN
        // Trap and redirect together while halted: trap vector, back in RUN
        drive("trap_pre", 0, 0, 0, 0, 1, 0);
        drive("trap", 0, 1, 1, 32'h0000_1002, 1, 1);
        chk("trap_dir", 64'({bus.halted, bus.fetch_valid, bus.misalign_err, bus.pc_out}),
            64'({1'b0, 1'b1, 1'b0, 32'h100}));
        drive("trap_acc", 0, 1, 0, 0, 0, 0);
`endif

        // Constrained random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            rdy = $urandom_range(0, 1) != 0;
            rv  = ($urandom_range(0, 7) == 0) && (m_st != M_BOOT);
            rpc = $urandom;
            hr  = ($urandom_range(0, 5) == 0);
            if (hr) rdy = 1'b0;
            tv  = ($urandom_range(0, 15) == 0);
            drive("rnd", r, rdy, rv, rpc, hr, tv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 Parameter INC, default 4, sequential PC increment.
REQ-004 Parameter TRAP_VECTOR, default 32'h0000_0100, trap target; used only when PC_TRAP_EN is defined.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 fetch_ready  input  1  IF consumer accepts current PC.
REQ-008 redirect_valid  input  1  branch/jump redirect request, single-cycle.
REQ-009 redirect_pc  input  XLEN  redirect target.
REQ-010 halt_req  input  1  level request to stop fetching.
REQ-011 trap_valid  input  1  trap request, single-cycle; present only when PC_TRAP_EN is defined.
REQ-012 pc_out  output  XLEN  current fetch address (registered).
REQ-013 fetch_valid  output  1  pc_out is a valid fetch offer (registered).
REQ-014 misalign_err  output  1  one-cycle pulse: accepted redirect target had nonzero bits [1:0].
REQ-015 halted  output  1  high while in HALT state.

Function
REQ-016 States: BOOT, RUN, HALT; state held in a registered FSM.
REQ-017 BOOT: entered on reset; fetch_valid=0; transitions to RUN after exactly one cycle without reset.
REQ-018 RUN: fetch_valid=1 unless halt_req is sampled 1, which moves FSM to HALT next cycle.
REQ-019 HALT: fetch_valid=0, halted=1, pc_out held; halt_req=0 returns to RUN next cycle.
REQ-020 Offer accepted when fetch_valid=1 and fetch_ready=1 in the same cycle; pc_out becomes pc_out+INC next cycle.
REQ-021 fetch_valid=1 and fetch_ready=0: pc_out and fetch_valid hold unchanged (stall).
REQ-022 Increment is modulo 2^XLEN; pc_out = 2^XLEN-INC accepted wraps to 0 with no flag.
REQ-023 redirect_valid=1: pc_out <= {redirect_pc[XLEN-1:2],2'b00} next cycle, regardless of fetch_ready; the current offer is discarded, not incremented.
REQ-024 Redirect with redirect_pc[1:0]!=0: misalign_err=1 the following cycle only; target still aligned per REQ-023.
REQ-025 Redirect in HALT or BOOT updates pc_out; FSM state unchanged; fetch_valid stays 0.
REQ-026 Priority per cycle: reset > trap_valid > redirect_valid > halt_req > accept/stall.
REQ-027 Redirect and halt_req same cycle in RUN: pc_out takes the redirect target and FSM enters HALT.
REQ-028 Redirect and acceptance same cycle: redirect wins; no increment applied.
REQ-029 Latency: every input acts on outputs exactly one cycle after sampling; no combinational input-to-output paths.

Reset
REQ-030 reset sampled 1: pc_out=RESET_VECTOR, fetch_valid=0, misalign_err=0, halted=0, FSM=BOOT next edge.
REQ-031 Reset mid-stall, mid-halt or coincident with redirect/trap: reset wins; all pending requests are dropped.

Configuration
REQ-032 Macro PC_TRAP_EN defined: trap_valid port exists; trap_valid=1 sets pc_out=TRAP_VECTOR next cycle, forces FSM to RUN (exits HALT), clears misalign_err, overrides redirect.
REQ-033 PC_TRAP_EN undefined: no trap_valid port, no trap logic; TRAP_VECTOR unused.

Verification
REQ-034 Reset 3 cycles, release, fetch_ready=1 -> cycle 1 fetch_valid=0 pc=0; then pc 0,4,8,12 with fetch_valid=1.
REQ-035 fetch_ready=0 for 3 cycles at pc=8 -> pc_out=8 held 3 cycles; ready=1 -> pc=12 next cycle.
REQ-036 redirect_valid with redirect_pc=32'h0000_1002 while ready=1 -> pc_out=32'h0000_1000, misalign_err high one cycle, no increment that cycle.
REQ-037 XLEN=32, pc_out=32'hFFFF_FFFC accepted -> pc_out=0, misalign_err=0.
REQ-038 halt_req=1 with redirect_pc=32'h200 same cycle -> halted=1, fetch_valid=0, pc_out=32'h200; halt_req=0 -> fetch resumes at 32'h200.
REQ-039 PC_TRAP_EN defined, trap_valid and redirect_valid same cycle while halted -> pc_out=32'h100, halted=0, fetch_valid=1.
